// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: command byte table,
// echo substitute for unknown bytes, echo FSM encoding, case folding helper.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RUNSTOP  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CLEAR    = 8'h43;  // 'C'
  localparam logic [7:0] CMD_SECUP    = 8'h53;  // 'S'
  localparam logic [7:0] CMD_MINUP    = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_HOURUP   = 8'h48;  // 'H'
  localparam logic [7:0] CMD_DIGIT0   = 8'h30;  // '0'
  localparam logic [7:0] CMD_DIGIT1   = 8'h31;  // '1'
  localparam logic [7:0] CMD_WATCH    = 8'h57;  // 'W'
  localparam logic [7:0] CMD_STOPW    = 8'h54;  // 'T'
  localparam logic [7:0] CMD_RELEASE  = 8'h58;  // 'X'
  localparam logic [7:0] ECHO_UNKNOWN = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_REQ  = 2'd1,
    E_WAIT = 2'd2
  } echo_state_t;

  // Lower-case ASCII letters map onto upper-case by clearing bit 5.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b & 8'hDF;
    return b;
  endfunction

  // True when the (already folded) byte is one of the recognised commands.
  function automatic logic is_command(input logic [7:0] b);
    case (b)
      CMD_RUNSTOP, CMD_CLEAR, CMD_SECUP, CMD_MINUP, CMD_HOURUP,
      CMD_DIGIT0, CMD_DIGIT1, CMD_WATCH, CMD_STOPW, CMD_RELEASE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_echo_ctrl.sv
// Echo request controller: latches one byte per decode event and hands it to
// uart_tx once the transmitter is free. No queue; events arriving while an
// echo is in flight are dropped.
//
// state  | meaning
// E_IDLE | nothing pending, next echo_req is latched
// E_REQ  | byte latched, waiting for tx_busy=0 to fire tx_start
// E_WAIT | guard cycle so tx_busy has time to rise after tx_start
module uart_echo_ctrl
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       echo_req,
  input  logic [7:0] echo_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  echo_state_t state;

  // Echo FSM and byte latch; the latch only loads from E_IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= E_IDLE;
      tx_data <= 8'h00;
    end else begin
      case (state)
        E_IDLE: begin
          if (echo_req) begin
            tx_data <= echo_byte;
            state   <= E_REQ;
          end
        end
        E_REQ: begin
          if (!tx_busy) state <= E_WAIT;
        end
        E_WAIT: state <= E_IDLE;
        default: state <= E_IDLE;
      endcase
    end
  end

  // Start strobe is issued in the same cycle the transmitter is seen idle.
  always_comb begin
    tx_start = (state == E_REQ) && !tx_busy;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes single ASCII bytes from uart_rx into stopwatch/watch command
// strobes and mode override levels, optionally echoing each byte to uart_tx.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ECHO_EN     = 1,
  parameter int unsigned CASE_INSENS = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       cmd_runstop,
  output logic       cmd_clear,
  output logic       cmd_secup,
  output logic       cmd_minup,
  output logic       cmd_hourup,
  output logic       cmd_digit_mode,
  output logic       cmd_mode0_trigger,
  output logic       cmd_watch_mode,
  output logic       cmd_mode1_trigger
);

  logic [7:0] key;
  logic       echo_req;
  logic [7:0] echo_byte;

  // Byte used for the table lookup, optionally case folded.
  always_comb begin
    key = rx_data;
    if (CASE_INSENS != 0) key = fold_case(rx_data);
  end

  // Command table: strobes last one cycle, levels hold until changed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_runstop       <= 1'b0;
      cmd_clear         <= 1'b0;
      cmd_secup         <= 1'b0;
      cmd_minup         <= 1'b0;
      cmd_hourup        <= 1'b0;
      cmd_digit_mode    <= 1'b0;
      cmd_mode0_trigger <= 1'b0;
      cmd_watch_mode    <= 1'b0;
      cmd_mode1_trigger <= 1'b0;
      echo_req          <= 1'b0;
      echo_byte         <= 8'h00;
    end else begin
      cmd_runstop <= 1'b0;
      cmd_clear   <= 1'b0;
      cmd_secup   <= 1'b0;
      cmd_minup   <= 1'b0;
      cmd_hourup  <= 1'b0;
      echo_req    <= rx_done;
      if (rx_done) begin
        echo_byte <= is_command(key) ? key : ECHO_UNKNOWN;
        case (key)
          CMD_RUNSTOP: cmd_runstop <= 1'b1;
          CMD_CLEAR:   cmd_clear   <= 1'b1;
          CMD_SECUP:   cmd_secup   <= 1'b1;
          CMD_MINUP:   cmd_minup   <= 1'b1;
          CMD_HOURUP:  cmd_hourup  <= 1'b1;
          CMD_DIGIT0: begin
            cmd_digit_mode    <= 1'b0;
            cmd_mode0_trigger <= 1'b1;
          end
          CMD_DIGIT1: begin
            cmd_digit_mode    <= 1'b1;
            cmd_mode0_trigger <= 1'b1;
          end
          CMD_STOPW: begin
            cmd_watch_mode    <= 1'b0;
            cmd_mode1_trigger <= 1'b1;
          end
          CMD_WATCH: begin
            cmd_watch_mode    <= 1'b1;
            cmd_mode1_trigger <= 1'b1;
          end
          CMD_RELEASE: begin
            cmd_mode0_trigger <= 1'b0;
            cmd_mode1_trigger <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  if (ECHO_EN != 0) begin : g_echo
    uart_echo_ctrl u_echo (
      .clk       (clk),
      .rst       (rst),
      .echo_req  (echo_req),
      .echo_byte (echo_byte),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data)
    );
  end else begin : g_no_echo
    assign tx_start = 1'b0;
    assign tx_data  = 8'h00;
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder. Three instances share the inputs:
// [0] echo on / case-insensitive, [1] echo on / case-sensitive,
// [2] echo off / case-insensitive. A behavioural model tracks commands,
// levels and the single-slot echo path.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic [2:0] txs, runstop, clear, secup, minup, hourup, digit, m0t, watch, m1t;
  logic [7:0] txd [3];

  always #5 clk = ~clk;

  uart_cmd_decoder #(.ECHO_EN(1), .CASE_INSENS(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_data(txd[0]), .tx_start(txs[0]), .cmd_runstop(runstop[0]), .cmd_clear(clear[0]),
    .cmd_secup(secup[0]), .cmd_minup(minup[0]), .cmd_hourup(hourup[0]),
    .cmd_digit_mode(digit[0]), .cmd_mode0_trigger(m0t[0]),
    .cmd_watch_mode(watch[0]), .cmd_mode1_trigger(m1t[0]));

  uart_cmd_decoder #(.ECHO_EN(1), .CASE_INSENS(0)) dut_cs (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_data(txd[1]), .tx_start(txs[1]), .cmd_runstop(runstop[1]), .cmd_clear(clear[1]),
    .cmd_secup(secup[1]), .cmd_minup(minup[1]), .cmd_hourup(hourup[1]),
    .cmd_digit_mode(digit[1]), .cmd_mode0_trigger(m0t[1]),
    .cmd_watch_mode(watch[1]), .cmd_mode1_trigger(m1t[1]));

  uart_cmd_decoder #(.ECHO_EN(0), .CASE_INSENS(1)) dut_ne (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_data(txd[2]), .tx_start(txs[2]), .cmd_runstop(runstop[2]), .cmd_clear(clear[2]),
    .cmd_secup(secup[2]), .cmd_minup(minup[2]), .cmd_hourup(hourup[2]),
    .cmd_digit_mode(digit[2]), .cmd_mode0_trigger(m0t[2]),
    .cmd_watch_mode(watch[2]), .cmd_mode1_trigger(m1t[2]));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // transmitter stub: busy for a random stretch after each start, plus forced busy
  bit force_busy = 1'b0;
  int busy_cnt   = 0;

  // reference model state; index 0 = case-insensitive, 1 = case-sensitive
  logic       prev_done;
  logic [7:0] prev_data;
  logic [4:0] exp_pulse [2];
  logic [3:0] exp_lvl   [2];
  logic       exp_start [2];
  logic [7:0] exp_data  [2];
  bit         m_digit [2], m_m0 [2], m_watch [2], m_m1 [2];
  bit         pend [2];
  logic [7:0] pend_byte [2];
  int         launch_min [2], free_at [2];
  logic [7:0] data_reg [2];

  logic [7:0] pool [20] = '{"R", "C", "S", "M", "H", "0", "1", "W", "T", "X",
                            "r", "c", "s", "m", "h", "w", "t", "x", 8'h0D, 8'h0A};

  function automatic logic [4:0] pulses_of(input int m);
    return {runstop[m], clear[m], secup[m], minup[m], hourup[m]};
  endfunction

  function automatic logic [3:0] levels_of(input int m);
    return {digit[m], m0t[m], watch[m], m1t[m]};
  endfunction

  // act: 0 none, 1 digit->0, 2 digit->1, 3 stopwatch, 4 watch, 5 release
  function automatic void ref_decode(input logic [7:0] b_in, input bit ci,
                                     output logic [4:0] pulse, output logic [7:0] echo,
                                     output int act);
    logic [7:0] b;
    b = b_in;
    if (ci && b >= "a" && b <= "z") b = b - 8'd32;
    pulse = 5'b0;
    act   = 0;
    echo  = b;
    case (b)
      "R": pulse = 5'b10000;
      "C": pulse = 5'b01000;
      "S": pulse = 5'b00100;
      "M": pulse = 5'b00010;
      "H": pulse = 5'b00001;
      "0": act = 1;
      "1": act = 2;
      "T": act = 3;
      "W": act = 4;
      "X": act = 5;
      default: echo = 8'h3F;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_digit[m] = 0; m_m0[m] = 0; m_watch[m] = 0; m_m1[m] = 0;
      pend[m] = 0; pend_byte[m] = 8'h00; launch_min[m] = 0; free_at[m] = 0;
      data_reg[m] = 8'h00; exp_pulse[m] = 5'b0; exp_lvl[m] = 4'b0;
      exp_start[m] = 0; exp_data[m] = 8'h00;
    end
    prev_done  = 0;
    prev_data  = 8'h00;
    busy_cnt   = 0;
    force_busy = 0;
  endtask

  // One clock cycle: drive inputs after the rising edge, sample and advance the model at the falling edge.
  task automatic tick(input logic done, input logic [7:0] data);
    logic [4:0] p;
    logic [7:0] e;
    int         a;
    @(posedge clk);
    #1;
    rx_done = done;
    rx_data = data;
    tx_busy = force_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    @(negedge clk);
    cyc++;
    for (int m = 0; m < 2; m++) begin
      exp_pulse[m] = 5'b0;
      p = 5'b0; e = 8'h00; a = 0;
      if (prev_done) begin
        ref_decode(prev_data, (m == 0), p, e, a);
        exp_pulse[m] = p;
        case (a)
          1: begin m_digit[m] = 0; m_m0[m] = 1; end
          2: begin m_digit[m] = 1; m_m0[m] = 1; end
          3: begin m_watch[m] = 0; m_m1[m] = 1; end
          4: begin m_watch[m] = 1; m_m1[m] = 1; end
          5: begin m_m0[m] = 0; m_m1[m] = 0; end
          default: ;
        endcase
      end
      exp_lvl[m] = {m_digit[m], m_m0[m], m_watch[m], m_m1[m]};
      exp_start[m] = 0;
      if (pend[m] && cyc >= launch_min[m] && !tx_busy) begin
        exp_start[m] = 1;
        pend[m]      = 0;
        free_at[m]   = cyc + 2;
      end
      exp_data[m] = data_reg[m];
      if (prev_done && !pend[m] && cyc >= free_at[m]) begin
        pend[m]       = 1;
        pend_byte[m]  = e;
        launch_min[m] = cyc + 1;
        data_reg[m]   = e;
      end
    end
    if (txs[0]) busy_cnt = $urandom_range(1, 6);
    prev_done = done;
    prev_data = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if ({pulses_of(m), levels_of(m), txs[m], txd[m]} !== 18'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected 0", m, {pulses_of(m), levels_of(m), txs[m], txd[m]});
      end
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_runstop_echo();
    tick(1'b1, "R");
    tick(1'b0, 8'h00);
    n_tests++;
    if (pulses_of(0) !== 5'b10000) begin
      n_fail++; $display("FAIL runstop_pulse: got %b expected 10000", pulses_of(0));
    end
    tick(1'b0, 8'h00);
    n_tests++;
    if (pulses_of(0) !== 5'b00000) begin
      n_fail++; $display("FAIL runstop_single: got %b expected 00000", pulses_of(0));
    end
    n_tests++;
    if (txs[0] !== 1'b1 || txd[0] !== 8'h52) begin
      n_fail++; $display("FAIL runstop_echo: got start=%b data=%h expected start=1 data=52", txs[0], txd[0]);
    end
    idle(10);
  endtask

  task automatic test_mode_levels();
    tick(1'b1, "W");
    tick(1'b0, 8'h00);
    n_tests++;
    if (levels_of(0) !== 4'b0011) begin
      n_fail++; $display("FAIL watch_level: got %b expected 0011", levels_of(0));
    end
    idle(8);
    tick(1'b1, "1");
    tick(1'b0, 8'h00);
    n_tests++;
    if (levels_of(0) !== 4'b1111) begin
      n_fail++; $display("FAIL digit_level: got %b expected 1111", levels_of(0));
    end
    idle(8);
    tick(1'b1, "X");
    tick(1'b0, 8'h00);
    n_tests++;
    if (levels_of(0) !== 4'b1010) begin
      n_fail++; $display("FAIL release: got %b expected 1010", levels_of(0));
    end
    idle(8);
  endtask

  task automatic test_case();
    bit found;
    tick(1'b1, "s");
    tick(1'b0, 8'h00);
    n_tests++;
    if (secup[0] !== 1'b1 || secup[1] !== 1'b0) begin
      n_fail++; $display("FAIL case_pulse: got ci=%b cs=%b expected ci=1 cs=0", secup[0], secup[1]);
    end
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1'b0, 8'h00);
      if (txs[0]) begin
        found = 1;
        n_tests++;
        if (txd[0] !== 8'h53 || txs[1] !== 1'b1 || txd[1] !== 8'h3F) begin
          n_fail++;
          $display("FAIL case_echo: got ci=%h cs=%b/%h expected ci=53 cs=1/3f", txd[0], txs[1], txd[1]);
        end
      end
    end
    if (!found) begin
      n_tests++; n_fail++; $display("FAIL case_echo_timeout: got no tx_start expected one");
    end
    idle(10);
  endtask

  task automatic test_busy_drop();
    int starts;
    logic [7:0] last;
    force_busy = 1;
    tick(1'b1, "C");
    tick(1'b0, 8'h00);
    n_tests++;
    if (clear[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_clear: got %b expected 1", clear[0]);
    end
    tick(1'b1, "M");
    tick(1'b0, 8'h00);
    n_tests++;
    if (minup[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_minup: got %b expected 1", minup[0]);
    end
    starts = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 8'h00);
      if (txs[0]) starts++;
    end
    n_tests++;
    if (starts != 0) begin
      n_fail++; $display("FAIL busy_hold: got %0d starts expected 0", starts);
    end
    force_busy = 0;
    starts = 0;
    last = 8'h00;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 8'h00);
      if (txs[0]) begin starts++; last = txd[0]; end
    end
    n_tests++;
    if (starts != 1 || last !== 8'h43) begin
      n_fail++; $display("FAIL busy_drop: got %0d starts data %h expected 1 start data 43", starts, last);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, "H");
    tick(1'b1, "S");
    n_tests++;
    if (pulses_of(0) !== 5'b00001) begin
      n_fail++; $display("FAIL b2b_first: got %b expected 00001", pulses_of(0));
    end
    tick(1'b0, 8'h00);
    n_tests++;
    if (pulses_of(0) !== 5'b00100) begin
      n_fail++; $display("FAIL b2b_second: got %b expected 00100", pulses_of(0));
    end
    idle(12);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       d;
    for (int i = 0; i < 600; i++) begin
      force_busy = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 19)];
      tick(d, b);
      for (int m = 0; m < 2; m++) begin
        n_tests++;
        if (pulses_of(m) !== exp_pulse[m]) begin
          n_fail++; $display("FAIL rnd_pulse[%0d] cyc %0d: got %b expected %b", m, cyc, pulses_of(m), exp_pulse[m]);
        end
        n_tests++;
        if (levels_of(m) !== exp_lvl[m]) begin
          n_fail++; $display("FAIL rnd_level[%0d] cyc %0d: got %b expected %b", m, cyc, levels_of(m), exp_lvl[m]);
        end
        n_tests++;
        if (txs[m] !== exp_start[m] || txd[m] !== exp_data[m]) begin
          n_fail++;
          $display("FAIL rnd_echo[%0d] cyc %0d: got %b/%h expected %b/%h", m, cyc, txs[m], txd[m], exp_start[m], exp_data[m]);
        end
      end
      n_tests++;
      if (pulses_of(2) !== exp_pulse[0] || levels_of(2) !== exp_lvl[0] || txs[2] !== 1'b0 || txd[2] !== 8'h00) begin
        n_fail++;
        $display("FAIL rnd_noecho cyc %0d: got %b/%b/%b/%h expected %b/%b/0/00", cyc,
                 pulses_of(2), levels_of(2), txs[2], txd[2], exp_pulse[0], exp_lvl[0]);
      end
    end
    force_busy = 0;
    idle(12);
  endtask

  task automatic test_reset_mid_echo();
    int starts;
    tick(1'b1, "W");
    idle(10);
    force_busy = 1;
    tick(1'b1, "R");
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({pulses_of(0), levels_of(0), txs[0], txd[0]} !== 18'h0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected 0", {pulses_of(0), levels_of(0), txs[0], txd[0]});
    end
    model_reset();
    #2;
    rst = 1'b1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00);
      if (txs[0]) starts++;
    end
    n_tests++;
    if (starts != 0) begin
      n_fail++; $display("FAIL reset_stale: got %0d starts expected 0", starts);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_runstop_echo();
    test_mode_levels();
    test_case();
    test_busy_drop();
    test_back_to_back();
    test_random();
    test_reset_mid_echo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
